sdio_card_cmd_responder: RTL and testbench



---
 rtl/sdio_card_cmd_responder.sv | 252 +++++++++++++++++++++++++
 tb/tb_sdio_card_cmd_responder.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdio_card_cmd_responder.sv
// ============================================================================
// Module   : sdio_card_cmd_responder
// Brief    : Card-side SDIO CMD line receiver, checker and response serialiser
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdio_card_cmd_responder #(
  parameter int NCR         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk_i,
  input  logic           rstn_i,
  input  logic           sdclk_i,
  input  logic           sdcmd_i,
  output logic           sdcmd_o,
  output logic           sdcmd_oen_o,
  output logic           cmd_valid_o,
  input  logic           cmd_ready_i,
  output logic [5:0]     cmd_index_o,
  output logic [31:0]    cmd_arg_o,
  input  logic           rsp_valid_i,
  output logic           rsp_ready_o,
  input  logic [1:0]     rsp_type_i,
  input  logic [5:0]     rsp_index_i,
  input  logic [119:0]   rsp_arg_i,
  output logic           busy_o,
  output logic           err_o
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RX       = 3'd1,
    ST_DELIVER  = 3'd2,
    ST_WAIT_RSP = 3'd3,
    ST_TX       = 3'd4
  } state_t;

  localparam logic [6:0] c_NCR        = 7'(NCR);
  localparam logic [5:0] c_RX_LAST    = 6'd46;
  localparam logic [5:0] c_RX_CRC_END = 6'd39;
  localparam logic [7:0] c_SHORT_BITS = 8'd48;
  localparam logic [7:0] c_LONG_BITS  = 8'd136;

  // CRC7, polynomial x^7 + x^3 + 1, one message bit per step.
  function automatic logic [6:0] f_crc7_step(input logic [6:0] crc, input logic b);
    logic fb;
    fb = crc[6] ^ b;
    return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
  endfunction

  function automatic logic [6:0] f_crc7_40(input logic [39:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 39; i >= 0; i--) c = f_crc7_step(c, d[i]);
    return c;
  endfunction

  function automatic logic [6:0] f_crc7_120(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) c = f_crc7_step(c, d[i]);
    return c;
  endfunction

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_cmd_sync;
  logic                   r_clk_prev;
  logic                   w_clk_s;
  logic                   w_cmd_s;
  logic                   w_rise;
  logic                   w_fall;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic                   w_cmd_valid;
  logic                   w_rsp_ready;
  logic                   w_busy;

  logic [5:0]             r_bit_cnt;
  logic [6:0]             r_crc;
  logic [45:0]            r_rx_sr;
  logic [46:0]            w_rx_full;
  logic                   w_rx_last;
  logic                   w_rx_ok;
  logic [5:0]             r_cmd_index;
  logic [31:0]            r_cmd_arg;
  logic                   r_err;

  logic [6:0]             r_ncr_cnt;
  logic                   w_ncr_count_en;

  logic [135:0]           r_tx_sr;
  logic [7:0]             r_tx_cnt;
  logic                   r_tx_active;
  logic                   r_sdcmd;
  logic                   r_sdcmd_oen;
  logic                   w_tx_done;
  logic                   w_rsp_load;

  logic [39:0]            w_short_hdr;
  logic [6:0]             w_short_crc;
  logic [6:0]             w_long_crc;
  logic [135:0]           w_tx_token;
  logic [7:0]             w_tx_len;

  // Both lines see the same latency so a sampled CMD bit lines up with its clock edge.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_clk_sync <= '0;
      r_cmd_sync <= '1;
      r_clk_prev <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], sdclk_i};
      r_cmd_sync <= {r_cmd_sync[SYNC_STAGES-2:0], sdcmd_i};
      r_clk_prev <= w_clk_s;
    end
  end

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
  assign w_cmd_s = r_cmd_sync[SYNC_STAGES-1];
  assign w_rise  =  w_clk_s & ~r_clk_prev;
  assign w_fall  = ~w_clk_s &  r_clk_prev;

  assign w_rx_full = {r_rx_sr, w_cmd_s};
  assign w_rx_last = (r_state == ST_RX) && w_rise && (r_bit_cnt == c_RX_LAST);
  assign w_rx_ok   = w_rx_full[46] && (w_rx_full[7:1] == r_crc) && w_rx_full[0];
  assign w_rsp_load = (r_state == ST_WAIT_RSP) && rsp_valid_i && (rsp_type_i != 2'b00);
  assign w_tx_done  = (r_state == ST_TX) && w_fall && r_tx_active && (r_tx_cnt == 8'd0);

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cmd_valid = 1'b0;
    w_rsp_ready = 1'b0;
    w_busy      = 1'b1;
    case (r_state)
      ST_IDLE: begin
        w_busy = 1'b0;
        if (w_rise && !w_cmd_s) w_state_nxt = ST_RX;
      end
      ST_RX: begin
        if (w_rx_last) w_state_nxt = w_rx_ok ? ST_DELIVER : ST_IDLE;
      end
      ST_DELIVER: begin
        w_cmd_valid = 1'b1;
        if (cmd_ready_i) w_state_nxt = ST_WAIT_RSP;
      end
      ST_WAIT_RSP: begin
        w_rsp_ready = 1'b1;
        if (rsp_valid_i) w_state_nxt = (rsp_type_i == 2'b00) ? ST_IDLE : ST_TX;
      end
      ST_TX: begin
        if (w_tx_done) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The start bit is always 0, so seeding the CRC with it leaves the register at zero.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_bit_cnt   <= '0;
      r_crc       <= '0;
      r_rx_sr     <= '0;
      r_cmd_index <= '0;
      r_cmd_arg   <= '0;
      r_err       <= 1'b0;
    end else begin
      r_err <= w_rx_last && !w_rx_ok;
      if ((r_state == ST_IDLE) && w_rise && !w_cmd_s) begin
        r_bit_cnt <= '0;
        r_crc     <= f_crc7_step(7'd0, w_cmd_s);
        r_rx_sr   <= '0;
      end else if ((r_state == ST_RX) && w_rise) begin
        r_rx_sr   <= {r_rx_sr[44:0], w_cmd_s};
        r_bit_cnt <= r_bit_cnt + 6'd1;
        if (r_bit_cnt < c_RX_CRC_END) r_crc <= f_crc7_step(r_crc, w_cmd_s);
        if (w_rx_last && w_rx_ok) begin
          r_cmd_index <= w_rx_full[45:40];
          r_cmd_arg   <= w_rx_full[39:8];
        end
      end
    end
  end

  // Counting carries on in TX until the start bit goes out, otherwise a
  // controller that answers before NCR has elapsed would stall the response.
  assign w_ncr_count_en = (r_state == ST_DELIVER) || (r_state == ST_WAIT_RSP) ||
                          ((r_state == ST_TX) && !r_tx_active);

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_ncr_cnt <= '0;
    end else if (w_rx_last && w_rx_ok) begin
      r_ncr_cnt <= '0;
    end else if (w_rise && w_ncr_count_en && (r_ncr_cnt != c_NCR)) begin
      r_ncr_cnt <= r_ncr_cnt + 7'd1;
    end
  end

  assign w_short_hdr = {2'b00, rsp_index_i, rsp_arg_i[31:0]};
  assign w_short_crc = (rsp_type_i == 2'b11) ? 7'h7F : f_crc7_40(w_short_hdr);
  assign w_long_crc  = f_crc7_120(rsp_arg_i);
  assign w_tx_token  = (rsp_type_i == 2'b10) ?
                       {2'b00, 6'h3F, rsp_arg_i, w_long_crc, 1'b1} :
                       {w_short_hdr, w_short_crc, 1'b1, 88'd0};
  assign w_tx_len    = (rsp_type_i == 2'b10) ? c_LONG_BITS : c_SHORT_BITS;

  // Tokens are left-aligned so the MSB always leaves first regardless of length.
  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_tx_sr     <= '0;
      r_tx_cnt    <= '0;
      r_tx_active <= 1'b0;
      r_sdcmd     <= 1'b1;
      r_sdcmd_oen <= 1'b1;
    end else if (w_rsp_load) begin
      r_tx_sr     <= w_tx_token;
      r_tx_cnt    <= w_tx_len;
      r_tx_active <= 1'b0;
    end else if ((r_state == ST_TX) && w_fall) begin
      if (r_tx_active && (r_tx_cnt == 8'd0)) begin
        r_sdcmd     <= 1'b1;
        r_sdcmd_oen <= 1'b1;
        r_tx_active <= 1'b0;
      end else if (r_tx_active || (r_ncr_cnt == c_NCR)) begin
        r_sdcmd     <= r_tx_sr[135];
        r_sdcmd_oen <= 1'b0;
        r_tx_sr     <= {r_tx_sr[134:0], 1'b0};
        r_tx_cnt    <= r_tx_cnt - 8'd1;
        r_tx_active <= 1'b1;
      end
    end
  end

  assign sdcmd_o     = r_sdcmd;
  assign sdcmd_oen_o = r_sdcmd_oen;
  assign cmd_valid_o = w_cmd_valid;
  assign rsp_ready_o = w_rsp_ready;
  assign busy_o      = w_busy;
  assign err_o       = r_err;
  assign cmd_index_o = r_cmd_index;
  assign cmd_arg_o   = r_cmd_arg;

endmodule

`default_nettype wire

// File: tb/tb_sdio_card_cmd_responder.sv
// ============================================================================
// Module   : tb_sdio_card_cmd_responder
// Brief    : Host/controller model with randomized commands and a CRC reference
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdio_card_cmd_responder;

  localparam int c_NCR_A = 2;
  localparam int c_NCR_B = 8;

  logic         sys_clk;
  logic         rstn_i;
  logic         sdclk;
  logic         sdcmd_i;

  logic         sdcmd_o, sdcmd_oen_o, cmd_valid_o, cmd_ready_i;
  logic [5:0]   cmd_index_o;
  logic [31:0]  cmd_arg_o;
  logic         rsp_valid_i, rsp_ready_o;
  logic [1:0]   rsp_type_i;
  logic [5:0]   rsp_index_i;
  logic [119:0] rsp_arg_i;
  logic         busy_o, err_o;

  logic         sdcmd_o2, sdcmd_oen_o2, cmd_valid_o2, cmd_ready_i2;
  logic [5:0]   cmd_index_o2;
  logic [31:0]  cmd_arg_o2;
  logic         rsp_valid_i2, rsp_ready_o2;
  logic [1:0]   rsp_type_i2;
  logic [5:0]   rsp_index_i2;
  logic [119:0] rsp_arg_i2;
  logic         busy_o2, err_o2;

  sdio_card_cmd_responder #(.NCR(c_NCR_A), .SYNC_STAGES(2)) u_dut (
    .sys_clk_i(sys_clk), .rstn_i(rstn_i), .sdclk_i(sdclk), .sdcmd_i(sdcmd_i),
    .sdcmd_o(sdcmd_o), .sdcmd_oen_o(sdcmd_oen_o),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_index_o(cmd_index_o), .cmd_arg_o(cmd_arg_o),
    .rsp_valid_i(rsp_valid_i), .rsp_ready_o(rsp_ready_o),
    .rsp_type_i(rsp_type_i), .rsp_index_i(rsp_index_i), .rsp_arg_i(rsp_arg_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Second card with a long NCR and an always-ready controller.
  sdio_card_cmd_responder #(.NCR(c_NCR_B), .SYNC_STAGES(2)) u_dut_ncr8 (
    .sys_clk_i(sys_clk), .rstn_i(rstn_i), .sdclk_i(sdclk), .sdcmd_i(sdcmd_i),
    .sdcmd_o(sdcmd_o2), .sdcmd_oen_o(sdcmd_oen_o2),
    .cmd_valid_o(cmd_valid_o2), .cmd_ready_i(cmd_ready_i2),
    .cmd_index_o(cmd_index_o2), .cmd_arg_o(cmd_arg_o2),
    .rsp_valid_i(rsp_valid_i2), .rsp_ready_o(rsp_ready_o2),
    .rsp_type_i(rsp_type_i2), .rsp_index_i(rsp_index_i2), .rsp_arg_i(rsp_arg_i2),
    .busy_o(busy_o2), .err_o(err_o2)
  );

  int n_checks = 0;
  int n_fails  = 0;

  int           rise_cnt = 0;
  int           end_rise = 0;
  int           hs_rise  = 0;
  int           rx_n, rx2_n, first_rise, first_rise2;
  logic [135:0] rx_bits, rx2_bits;
  int           cmd_cnt = 0;
  int           err_cnt = 0;
  int           err2_cnt = 0;
  logic [5:0]   cap_idx0, cap_idx1;
  logic [31:0]  cap_arg0, cap_arg1;

  logic [1:0]   ctl_type;
  logic [5:0]   ctl_idx;
  logic [119:0] ctl_arg;
  int           ctl_delay;

  task automatic check_eq(input string tag, input logic [135:0] obs, input logic [135:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference CRC7 as polynomial long division of msg * x^7 by x^7 + x^3 + 1.
  function automatic logic [6:0] m_crc7(input logic [135:0] msg, input int n);
    logic [7:0] r;
    logic       b;
    r = 8'd0;
    for (int i = n - 1; i >= -7; i--) begin
      b = 1'b0;
      if (i >= 0) b = msg[i];
      r = {r[6:0], b};
      if (r[7]) r = r ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] mk_cmd(input logic [5:0] idx, input logic [31:0] arg);
    logic [39:0] h;
    h = {2'b01, idx, arg};
    return {h, m_crc7(136'(h), 40), 1'b1};
  endfunction

  function automatic void m_rsp(input logic [1:0] t, input logic [5:0] i, input logic [119:0] a,
                                output logic [135:0] v, output int len);
    logic [39:0] h;
    logic [6:0]  c;
    if (t == 2'b10) begin
      v   = {2'b00, 6'h3F, a, m_crc7(136'(a), 120), 1'b1};
      len = 136;
    end else begin
      h   = {2'b00, i, a[31:0]};
      c   = (t == 2'b11) ? 7'h7F : m_crc7(136'(h), 40);
      v   = 136'({h, c, 1'b1});
      len = 48;
    end
  endfunction

  initial begin
    sys_clk = 1'b0;
    forever #5 sys_clk = ~sys_clk;
  end

  // One SD clock period; card outputs are sampled on the host's rising edge.
  task automatic tick();
    sdclk = 1'b0;
    #80;
    sdclk = 1'b1;
    rise_cnt++;
    if (sdcmd_oen_o === 1'b0) begin
      if (rx_n == 0) first_rise = rise_cnt;
      rx_bits = {rx_bits[134:0], sdcmd_o};
      rx_n++;
    end
    if (sdcmd_oen_o2 === 1'b0) begin
      if (rx2_n == 0) first_rise2 = rise_cnt;
      rx2_bits = {rx2_bits[134:0], sdcmd_o2};
      rx2_n++;
    end
    #80;
  endtask

  task automatic send_token(input logic [47:0] tok);
    rx_n = 0; rx_bits = '0; first_rise = 0;
    rx2_n = 0; rx2_bits = '0; first_rise2 = 0;
    for (int i = 47; i >= 0; i--) begin
      sdcmd_i = tok[i];
      tick();
    end
    end_rise = rise_cnt;
    sdcmd_i  = 1'b1;
  endtask

  task automatic run_txn(input string tag, input logic [47:0] tok, input bit good,
                         input logic [1:0] rtype, input logic [5:0] ridx,
                         input logic [119:0] rarg, input int delay_sd);
    int           c0, e0, e20, elen, elen2, exp_fr;
    logic [135:0] ev, ev2;
    bit           done;
    ctl_type  = rtype;
    ctl_idx   = ridx;
    ctl_arg   = rarg;
    ctl_delay = 16 * delay_sd;
    c0 = cmd_cnt; e0 = err_cnt; e20 = err2_cnt;
    send_token(tok);
    done = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (busy_o === 1'b0 && busy_o2 === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check_eq({tag, " idle"}, done, 1'b1);
    check_eq({tag, " cmds"}, cmd_cnt - c0, good ? 1 : 0);
    check_eq({tag, " err"}, err_cnt - e0, good ? 0 : 1);
    check_eq({tag, " err ncr8"}, err2_cnt - e20, good ? 0 : 1);
    check_eq({tag, " line idle"}, {sdcmd_oen_o, sdcmd_o}, 2'b11);
    if (good) begin
      check_eq({tag, " index"}, cap_idx0, tok[45:40]);
      check_eq({tag, " arg"}, cap_arg0, tok[39:8]);
      check_eq({tag, " held"}, {cap_idx1, cap_arg1}, {tok[45:40], tok[39:8]});
      if (rtype == 2'b00) begin
        check_eq({tag, " no drive"}, rx_n, 0);
      end else begin
        m_rsp(rtype, ridx, rarg, ev, elen);
        exp_fr = end_rise + c_NCR_A + 1;
        if (hs_rise + 1 > exp_fr) exp_fr = hs_rise + 1;
        check_eq({tag, " rsp len"}, rx_n, elen);
        check_eq({tag, " rsp bits"}, rx_bits, ev);
        check_eq({tag, " rsp start"}, first_rise, exp_fr);
      end
      m_rsp(2'b01, rsp_index_i2, rsp_arg_i2, ev2, elen2);
      check_eq({tag, " ncr8 len"}, rx2_n, elen2);
      check_eq({tag, " ncr8 bits"}, rx2_bits, ev2);
      check_eq({tag, " ncr8 start"}, first_rise2 - end_rise, c_NCR_B + 1);
    end else begin
      check_eq({tag, " no rsp"}, rx_n, 0);
    end
  endtask

  // Local controller for the NCR=2 card.
  initial begin
    cmd_ready_i = 1'b0; rsp_valid_i = 1'b0;
    rsp_type_i = '0; rsp_index_i = '0; rsp_arg_i = '0;
    forever begin
      @(posedge sys_clk); #1;
      if (cmd_valid_o === 1'b1) begin
        cmd_cnt++;
        cap_idx0 = cmd_index_o;
        cap_arg0 = cmd_arg_o;
        repeat (ctl_delay) @(posedge sys_clk);
        #1;
        cap_idx1 = cmd_index_o;
        cap_arg1 = cmd_arg_o;
        cmd_ready_i = 1'b1;
        @(posedge sys_clk); #1;
        cmd_ready_i = 1'b0;
        rsp_type_i  = ctl_type;
        rsp_index_i = ctl_idx;
        rsp_arg_i   = ctl_arg;
        rsp_valid_i = 1'b1;
        for (int k = 0; k < 8 && rsp_ready_o !== 1'b1; k++) begin
          @(posedge sys_clk); #1;
        end
        @(posedge sys_clk);
        hs_rise = rise_cnt;
        #1;
        rsp_valid_i = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge sys_clk); #1;
      if (err_o === 1'b1)  err_cnt++;
      if (err_o2 === 1'b1) err2_cnt++;
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [47:0]  tok;
    logic [119:0] rarg;
    logic [1:0]   rt;
    bit           bad;
    int           p, c0, e0, guard;

    cmd_ready_i2 = 1'b1;
    rsp_valid_i2 = 1'b1;
    rsp_type_i2  = 2'b01;
    rsp_index_i2 = 6'h2A;
    rsp_arg_i2   = 120'hDEADBEEF;
    ctl_type = 2'b00; ctl_idx = '0; ctl_arg = '0; ctl_delay = 0;
    rx_n = 0; rx2_n = 0; rx_bits = '0; rx2_bits = '0;
    first_rise = 0; first_rise2 = 0;

    rstn_i = 1'b0; sdclk = 1'b0; sdcmd_i = 1'b1;
    repeat (3) @(posedge sys_clk);
    #2;
    check_eq("reset line", {sdcmd_oen_o, sdcmd_o}, 2'b11);
    check_eq("reset flags", {cmd_valid_o, rsp_ready_o, busy_o, err_o}, 4'b0000);
    check_eq("reset cmd regs", {cmd_index_o, cmd_arg_o}, 38'd0);
    rstn_i = 1'b1;
    repeat (3) tick();

    run_txn("cmd0", 48'h40_0000_0000_95, 1'b1, 2'b00, 6'd0, 120'd0, 0);
    check_eq("cmd0 busy", busy_o, 1'b0);

    run_txn("cmd8 r7", 48'h48_0000_01AA_87, 1'b1, 2'b01, 6'd8, 120'h1AA, 0);
    check_eq("cmd8 r7 token", rx_bits, 136'h08_0000_01AA_13);
    check_eq("cmd8 ncr", first_rise - end_rise, 3);

    // Corrupt CRC, then a good CMD17 with no idle bit in between.
    c0 = cmd_cnt; e0 = err_cnt;
    send_token(48'h51_0000_0000_55 ^ 48'h8);
    check_eq("cmd17 bad err", err_cnt - e0, 1);
    check_eq("cmd17 bad valid", cmd_cnt - c0, 0);
    run_txn("cmd17", 48'h51_0000_0000_55, 1'b1, 2'b01, 6'd17, 120'h900, 0);

    run_txn("slow ctl", mk_cmd(6'd55, 32'h1234_0000), 1'b1, 2'b01, 6'd55, 120'h120, 10);
    check_eq("slow ctl start", first_rise, hs_rise + 1);

    run_txn("r2", mk_cmd(6'd2, 32'd0), 1'b1, 2'b10, 6'd2,
            120'h0123456789ABCDEF0123456789ABEF, 0);
    run_txn("r3", mk_cmd(6'd41, 32'h40FF_8000), 1'b1, 2'b11, 6'h3F, 120'h80FF_8000, 1);
    check_eq("r3 crc field", rx_bits[7:1], 7'h7F);

    // Reset in the middle of a long response bit.
    ctl_type = 2'b10; ctl_idx = '0; ctl_arg = 120'hA5A5_5A5A_0F0F; ctl_delay = 0;
    send_token(mk_cmd(6'd2, 32'd0));
    guard = 0;
    while (rx_n < 20 && guard < 100) begin
      tick();
      guard++;
    end
    check_eq("mid tx reached", rx_n >= 20, 1'b1);
    sdclk = 1'b0;
    #40;
    rstn_i = 1'b0;
    #1;
    check_eq("mid tx reset line", {sdcmd_oen_o, sdcmd_o}, 2'b11);
    check_eq("mid tx reset busy", {busy_o, cmd_valid_o}, 2'b00);
    #39;
    sdclk = 1'b1;
    rise_cnt++;
    #80;
    rstn_i = 1'b1;
    repeat (2) tick();
    run_txn("after reset", 48'h48_0000_01AA_87, 1'b1, 2'b01, 6'd8, 120'h1AA, 0);

    for (int n = 0; n < 8; n++) begin
      tok  = mk_cmd(6'($urandom_range(63, 0)), $urandom);
      rt   = 2'($urandom_range(3, 0));
      rarg = {$urandom, $urandom, $urandom, $urandom} >> 8;
      bad  = ($urandom_range(3, 0) == 0);
      if (bad) begin
        p = $urandom_range(46, 0);
        tok[p] = ~tok[p];
      end
      run_txn("random", tok, !bad, rt, 6'($urandom_range(63, 0)), rarg,
              $urandom_range(4, 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
